// File: rtl/kypd_pkg.sv
// Shared key codes, octave encodings, player states and queue entry layout
// for the keypad note queue.
package kypd_pkg;

  localparam logic [3:0] KEY_0 = 4'h0;
  localparam logic [3:0] KEY_1 = 4'h1;
  localparam logic [3:0] KEY_2 = 4'h2;
  localparam logic [3:0] KEY_3 = 4'h3;
  localparam logic [3:0] KEY_4 = 4'h4;
  localparam logic [3:0] KEY_5 = 4'h5;
  localparam logic [3:0] KEY_6 = 4'h6;
  localparam logic [3:0] KEY_7 = 4'h7;
  localparam logic [3:0] KEY_8 = 4'h8;
  localparam logic [3:0] KEY_9 = 4'h9;
  localparam logic [3:0] KEY_A = 4'hA;
  localparam logic [3:0] KEY_B = 4'hB;
  localparam logic [3:0] KEY_C = 4'hC;
  localparam logic [3:0] KEY_D = 4'hD;
  localparam logic [3:0] KEY_E = 4'hE;
  localparam logic [3:0] KEY_F = 4'hF;

  localparam logic [1:0] OCT_LOW  = 2'd0;
  localparam logic [1:0] OCT_MID  = 2'd1;
  localparam logic [1:0] OCT_HIGH = 2'd2;

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_NOTE = 2'd1,
    ST_GAP  = 2'd2
  } play_state_e;

  typedef struct packed {
    logic [1:0] octave;
    logic [2:0] note;
  } note_entry_t;

endpackage

// File: rtl/kypd_note_fifo.sv
// Synchronous note FIFO with head pop, newest-entry drop and bulk clear.
module kypd_note_fifo
  import kypd_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     drop_tail,
  input  logic [4:0]               din,
  output logic [4:0]               dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  note_entry_t   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop, do_drop;

  always_comb begin
    // A pop frees a slot this cycle, so a push into a full queue still lands;
    // a drop on the last entry loses to a simultaneous pop.
    do_pop   = pop & (count_q != '0);
    do_push  = push & ((count_q != CW'(DEPTH)) | do_pop);
    do_drop  = drop_tail & ~push & (count_q != '0) & ~(do_pop & (count_q == CW'(1)));
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push)      wr_ptr_d = wr_ptr_q + AW'(1);
      else if (do_drop) wr_ptr_d = wr_ptr_q - AW'(1);
      if (do_pop)       rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop) - CW'(do_drop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/kypd_note_queue.sv
// Keypad-driven note sequencer: decodes key presses into queue edits and
// plays queued entries as timed notes separated by silent gaps.
module kypd_note_queue
  import kypd_pkg::*;
#(
  parameter int NOTE_CYC = 25_000_000,
  parameter int GAP_CYC  = 5_000_000,
  parameter int DEPTH    = 16
) (
  input  logic                   clk,
  input  logic                   sys_rst,
  input  logic [3:0]             key_code,
  input  logic                   key_valid,
  output logic                   note_valid,
  output logic [2:0]             note_idx,
  output logic [1:0]             octave,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   full,
  output logic                   empty,
  output logic                   playing,
  output logic                   overflow
);

  localparam int TW = $clog2((NOTE_CYC > GAP_CYC ? NOTE_CYC : GAP_CYC) + 1);

  logic          key_prev_q, arm_q, key_ev;
  logic [1:0]    cur_oct_q, cur_oct_d;
  logic          playing_q, playing_d, overflow_q, overflow_d;
  play_state_e   state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          note_valid_q, note_valid_d;
  logic [2:0]    note_idx_q, note_idx_d;
  logic [1:0]    octave_q, octave_d;
  logic          push_req, drop_req, ev_toggle, ev_clear, stop_req, start, pop;
  logic [2:0]    push_note;
  logic [4:0]    fifo_dout;
  note_entry_t   head;

  // arm_q masks the first post-reset cycle so a key already held at release is not an event
  assign key_ev = key_valid & ~key_prev_q & arm_q;
  assign head   = fifo_dout;

  always_comb begin
    push_req  = 1'b0;
    drop_req  = 1'b0;
    ev_toggle = 1'b0;
    ev_clear  = 1'b0;
    push_note = 3'd0;
    cur_oct_d = cur_oct_q;
    if (key_ev) begin
      case (key_code)
        KEY_0, KEY_1, KEY_2, KEY_3,
        KEY_4, KEY_5, KEY_6, KEY_7: begin
          push_req  = 1'b1;
          push_note = key_code[2:0];
        end
        KEY_8, KEY_9: ;
        KEY_A: cur_oct_d = OCT_LOW;
        KEY_B: cur_oct_d = OCT_MID;
        KEY_C: cur_oct_d = OCT_HIGH;
        KEY_D: drop_req  = 1'b1;
        KEY_E: ev_toggle = 1'b1;
        KEY_F: ev_clear  = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    stop_req     = ev_clear | (ev_toggle & playing_q);
    start        = 1'b0;
    state_d      = state_q;
    timer_d      = timer_q;
    note_valid_d = note_valid_q;
    note_idx_d   = note_idx_q;
    octave_d     = octave_q;
    playing_d    = ev_clear ? 1'b0 : (playing_q ^ ev_toggle);
    if (stop_req) begin
      state_d      = ST_STOP;
      timer_d      = '0;
      note_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_STOP: start = playing_q & ~empty;
        ST_NOTE: begin
          if (timer_q == '0) begin
            state_d      = ST_GAP;
            timer_d      = TW'(GAP_CYC - 1);
            note_valid_d = 1'b0;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
        ST_GAP: begin
          if (timer_q == '0) begin
            if (playing_q && !empty) begin
              start = 1'b1;
            end else begin
              state_d = ST_STOP;
              if (empty && playing_q) playing_d = 1'b0;
            end
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
        default: state_d = ST_STOP;
      endcase
    end
    if (start) begin
      state_d      = ST_NOTE;
      timer_d      = TW'(NOTE_CYC - 1);
      note_valid_d = 1'b1;
      note_idx_d   = head.note;
      octave_d     = head.octave;
    end
    pop        = start;
    overflow_d = ev_clear ? 1'b0 : (overflow_q | (push_req & full & ~pop));
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      key_prev_q   <= 1'b0;
      arm_q        <= 1'b0;
      cur_oct_q    <= OCT_MID;
      playing_q    <= 1'b0;
      overflow_q   <= 1'b0;
      state_q      <= ST_STOP;
      timer_q      <= '0;
      note_valid_q <= 1'b0;
      note_idx_q   <= 3'd0;
      octave_q     <= OCT_MID;
    end else begin
      key_prev_q   <= key_valid;
      arm_q        <= 1'b1;
      cur_oct_q    <= cur_oct_d;
      playing_q    <= playing_d;
      overflow_q   <= overflow_d;
      state_q      <= state_d;
      timer_q      <= timer_d;
      note_valid_q <= note_valid_d;
      note_idx_q   <= note_idx_d;
      octave_q     <= octave_d;
    end
  end

  kypd_note_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (sys_rst),
    .clear     (ev_clear),
    .push      (push_req),
    .pop       (pop),
    .drop_tail (drop_req),
    .din       ({cur_oct_q, push_note}),
    .dout      (fifo_dout),
    .count     (fifo_count),
    .full      (full),
    .empty     (empty)
  );

  assign note_valid = note_valid_q;
  assign note_idx   = note_idx_q;
  assign octave     = octave_q;
  assign playing    = playing_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_kypd_note_queue.sv
// Directed bench for kypd_note_queue with short note/gap timing and a 4-deep queue.
module tb_kypd_note_queue;

  logic       clk = 1'b0;
  logic       sys_rst;
  logic [3:0] key_code;
  logic       key_valid;
  logic       note_valid;
  logic [2:0] note_idx;
  logic [1:0] octave;
  logic [2:0] fifo_count;
  logic       full, empty, playing, overflow;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  kypd_note_queue #(.NOTE_CYC(4), .GAP_CYC(2), .DEPTH(4)) dut (
    .clk        (clk),
    .sys_rst    (sys_rst),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .note_valid (note_valid),
    .note_idx   (note_idx),
    .octave     (octave),
    .fifo_count (fifo_count),
    .full       (full),
    .empty      (empty),
    .playing    (playing),
    .overflow   (overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One press: key_valid high for a single cycle, released on the next negedge.
  task automatic press(input logic [3:0] code);
    @(negedge clk);
    key_code  = code;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  initial begin
    sys_rst   = 1'b1;
    key_valid = 1'b1;
    key_code  = 4'h1;
    repeat (3) @(negedge clk);
    sys_rst = 1'b0;
    chk("rst_nv", note_valid, 0);
    chk("rst_idx", note_idx, 0);
    chk("rst_oct", octave, 1);
    chk("rst_cnt", fifo_count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_play", playing, 0);
    chk("rst_ovf", overflow, 0);
    repeat (3) @(negedge clk);
    chk("held_at_release", fifo_count, 0);
    key_valid = 1'b0;
    @(negedge clk);

    // Song: 1 (mid), then 5 (high)
    press(4'h1);
    chk("song_cnt1", fifo_count, 1);
    press(4'hC);
    press(4'h5);
    chk("song_cnt2", fifo_count, 2);
    press(4'hE);
    chk("song_play_on", playing, 1);
    chk("song_nv_pre", note_valid, 0);
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      chk($sformatf("song_nv_k%0d", k), note_valid,
          ((k >= 1 && k <= 4) || (k >= 7 && k <= 10)) ? 1 : 0);
      if (k == 1) begin
        chk("song_idx1", note_idx, 1);
        chk("song_oct1", octave, 1);
      end
      if (k == 7) begin
        chk("song_idx5", note_idx, 5);
        chk("song_oct5", octave, 2);
      end
      if (k == 12) chk("song_play_k12", playing, 1);
    end
    chk("song_end_play", playing, 0);
    chk("song_end_empty", empty, 1);

    // Overflow then clear
    for (int i = 0; i < 5; i++) press(4'h3);
    chk("ovf_cnt", fifo_count, 4);
    chk("ovf_full", full, 1);
    chk("ovf_flag", overflow, 1);
    press(4'hF);
    chk("clr_cnt", fifo_count, 0);
    chk("clr_ovf", overflow, 0);
    chk("clr_full", full, 0);

    // Long hold is one event
    @(negedge clk);
    key_code  = 4'h2;
    key_valid = 1'b1;
    repeat (100) @(negedge clk);
    key_valid = 1'b0;
    @(negedge clk);
    chk("hold_cnt", fifo_count, 1);
    press(4'hF);

    // Drop newest then play the remaining one
    press(4'h4);
    press(4'h6);
    press(4'hD);
    chk("drop_cnt", fifo_count, 1);
    press(4'hE);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("drop_idx", note_idx, 4);
        chk("drop_nv1", note_valid, 1);
        chk("drop_cnt0", fifo_count, 0);
      end
      if (k == 4) chk("drop_nv4", note_valid, 1);
      if (k == 5) chk("drop_nv5", note_valid, 0);
      if (k == 7) chk("drop_play_off", playing, 0);
      if (k == 8) chk("drop_nv8", note_valid, 0);
    end

    // Stop mid-note keeps remaining entries
    press(4'h1);
    press(4'h2);
    press(4'h3);
    press(4'hE);
    @(negedge clk);
    chk("stop_nv_on", note_valid, 1);
    chk("stop_idx", note_idx, 1);
    chk("stop_cnt_a", fifo_count, 2);
    press(4'hE);
    chk("stop_nv_off", note_valid, 0);
    chk("stop_play", playing, 0);
    chk("stop_cnt_b", fifo_count, 2);
    repeat (8) @(negedge clk);
    chk("stop_nv_idle", note_valid, 0);
    chk("stop_cnt_idle", fifo_count, 2);

    // Reset mid-note with 3 entries still queued
    press(4'h4);
    press(4'h5);
    chk("rn_full", full, 1);
    press(4'hE);
    @(negedge clk);
    chk("rn_nv_on", note_valid, 1);
    chk("rn_idx", note_idx, 2);
    chk("rn_cnt3", fifo_count, 3);
    sys_rst = 1'b1;
    @(negedge clk);
    chk("rn_nv", note_valid, 0);
    chk("rn_cnt", fifo_count, 0);
    chk("rn_oct", octave, 1);
    chk("rn_play", playing, 0);
    chk("rn_empty", empty, 1);
    sys_rst = 1'b0;
    @(negedge clk);

    // Ignored keys, low octave, rest entry
    press(4'h8);
    press(4'h9);
    chk("ign_cnt", fifo_count, 0);
    press(4'hA);
    press(4'h0);
    chk("rest_cnt", fifo_count, 1);
    press(4'hE);
    @(negedge clk);
    chk("rest_nv", note_valid, 1);
    chk("rest_idx", note_idx, 0);
    chk("rest_oct", octave, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
